pc_epc_unit: RTL and testbench



---
 rtl/pc_epc_unit.sv | 129 ++++++++++++
 tb/tb_pc_epc_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_epc_unit.sv
// Program counter with exception entry sequencing.
// Normal operation loads the PC from the PC-source mux on an unconditional
// or condition-qualified request. An exception (invalid opcode, overflow or a
// misaligned load target) freezes the PC, saves the faulting address into EPC
// with its cause, and then redirects the PC to the matching handler vector.
module pc_epc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] VEC_OPCODE = 32'h0000_0080,
  parameter logic [31:0] VEC_OVF    = 32'h0000_0084,
  parameter logic [31:0] VEC_ALIGN  = 32'h0000_0088
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        cond_true,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        exc_busy
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SAVE   = 2'd1,
    VECTOR = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN  = 2'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;
  logic [1:0]  r_pend_cause;
  logic [31:0] r_pend_vec;

  logic        w_load_en;
  logic        w_misalign;
  logic        w_exc_req;
  logic [1:0]  w_req_cause;
  logic [31:0] w_req_vec;
  logic [31:0] w_epc_val;

  // Decode the load request and pick the highest-priority exception source.
  always_comb begin
    w_load_en   = pc_write | (pc_write_cond & cond_true);
    w_misalign  = w_load_en & (next_pc[1:0] != 2'b00);
    w_exc_req   = 1'b0;
    w_req_cause = CAUSE_NONE;
    w_req_vec   = 32'h0000_0000;
    if (exc_opcode) begin
      w_exc_req   = 1'b1;
      w_req_cause = CAUSE_OPCODE;
      w_req_vec   = VEC_OPCODE;
    end else if (exc_ovf) begin
      w_exc_req   = 1'b1;
      w_req_cause = CAUSE_OVF;
      w_req_vec   = VEC_OVF;
    end else if (w_misalign) begin
      w_exc_req   = 1'b1;
      w_req_cause = CAUSE_ALIGN;
      w_req_vec   = VEC_ALIGN;
    end
    // Opcode/overflow faults are reported after the PC has already advanced
    // past the faulting instruction; a misaligned target never loaded, so
    // the current PC is itself the address to resume from.
    w_epc_val = (r_pend_cause == CAUSE_ALIGN) ? r_pc : (r_pc - 32'd4);
  end

  // Next-state logic: RUN leaves only on an exception, entry always takes
  // exactly two further steps.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_exc_req) w_state_nxt = SAVE;
      SAVE:    w_state_nxt = VECTOR;
      VECTOR:  w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // State register and all architectural/pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_epc        <= 32'h0000_0000;
      r_cause      <= CAUSE_NONE;
      r_pend_cause <= CAUSE_NONE;
      r_pend_vec   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        RUN: begin
          // An exception wins over a simultaneous load; the PC stays frozen.
          if (w_exc_req) begin
            r_pend_cause <= w_req_cause;
            r_pend_vec   <= w_req_vec;
          end else if (w_load_en) begin
            r_pc <= next_pc;
          end
        end
        SAVE: begin
          r_epc   <= w_epc_val;
          r_cause <= r_pend_cause;
        end
        VECTOR: begin
          // Handler vectors bypass the alignment check.
          r_pc <= r_pend_vec;
        end
        default: ;
      endcase
    end
  end

  assign pc       = r_pc;
  assign epc      = r_epc;
  assign cause    = r_cause;
  assign exc_busy = (r_state != RUN);

endmodule

// File: tb/tb_pc_epc_unit.sv
// Bench for pc_epc_unit: a cycle-level reference model predicts the
// registered outputs for every driven cycle; predictions are queued and
// compared after the clock edge that should produce them.
module tb_pc_epc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] VEC_OPCODE = 32'h0000_0080;
  localparam logic [31:0] VEC_OVF    = 32'h0000_0084;
  localparam logic [31:0] VEC_ALIGN  = 32'h0000_0088;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic        cond_true;
  logic        exc_opcode;
  logic        exc_ovf;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        exc_busy;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;
  int          m_ph;      // 0 run, 1 save, 2 vector
  logic [1:0]  m_pcause;
  logic [31:0] m_pvec;

  pc_epc_unit #(
    .RESET_PC  (RESET_PC),
    .VEC_OPCODE(VEC_OPCODE),
    .VEC_OVF   (VEC_OVF),
    .VEC_ALIGN (VEC_ALIGN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .cond_true    (cond_true),
    .exc_opcode   (exc_opcode),
    .exc_ovf      (exc_ovf),
    .pc           (pc),
    .epc          (epc),
    .cause        (cause),
    .exc_busy     (exc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one edge with the given inputs.
  task automatic model_step(input logic rst, input logic [31:0] npc, input logic pw,
                            input logic pwc, input logic ct, input logic eo, input logic ev);
    logic le;
    if (rst) begin
      m_pc = RESET_PC; m_epc = 32'h0; m_cause = 2'd0; m_ph = 0;
      m_pcause = 2'd0; m_pvec = 32'h0;
    end else if (m_ph == 1) begin
      m_epc   = (m_pcause == 2'd3) ? m_pc : m_pc - 32'd4;
      m_cause = m_pcause;
      m_ph    = 2;
    end else if (m_ph == 2) begin
      m_pc = m_pvec;
      m_ph = 0;
    end else begin
      le = pw || (pwc && ct);
      if (eo) begin
        m_pcause = 2'd1; m_pvec = VEC_OPCODE; m_ph = 1;
      end else if (ev) begin
        m_pcause = 2'd2; m_pvec = VEC_OVF; m_ph = 1;
      end else if (le && (npc[1:0] != 2'b00)) begin
        m_pcause = 2'd3; m_pvec = VEC_ALIGN; m_ph = 1;
      end else if (le) begin
        m_pc = npc;
      end
    end
  endtask

  // Drive one cycle, queue the prediction, and compare after the edge.
  task automatic step(input logic rst, input logic [31:0] npc, input logic pw,
                      input logic pwc, input logic ct, input logic eo, input logic ev);
    exp_t e;
    exp_t g;
    reset = rst; next_pc = npc; pc_write = pw; pc_write_cond = pwc;
    cond_true = ct; exc_opcode = eo; exc_ovf = ev;
    model_step(rst, npc, pw, pwc, ct, eo, ev);
    e.pc = m_pc; e.epc = m_epc; e.cause = m_cause; e.busy = (m_ph != 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: queue empty, got 0 expected 1");
    end else begin
      g = exp_q.pop_front();
      chk("pc",    pc,                 g.pc);
      chk("epc",   epc,                g.epc);
      chk("cause", {30'd0, cause},     {30'd0, g.cause});
      chk("busy",  {31'd0, exc_busy},  {31'd0, g.busy});
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b0, a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'd0; m_ph = 0; m_pcause = 2'd0; m_pvec = 32'h0;
    reset = 1'b1; next_pc = 32'h0; pc_write = 1'b0; pc_write_cond = 1'b0;
    cond_true = 1'b0; exc_opcode = 1'b0; exc_ovf = 1'b0;
    #1;

    // Reset state
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_epc", epc, 32'h0);
    chk("rst_busy", {31'd0, exc_busy}, 32'd0);

    // Simple unconditional load
    load(32'h4);
    chk("load4_pc", pc, 32'h4);
    chk("load4_busy", {31'd0, exc_busy}, 32'd0);
    idle();
    chk("hold_pc", pc, 32'h4);

    // Conditional load, not taken then taken
    load(32'h10);
    step(1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cond0_pc", pc, 32'h10);
    step(1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cond1_pc", pc, 32'h40);

    // Overflow overriding a simultaneous load
    load(32'h24);
    step(1'b0, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_hold_pc", pc, 32'h24);
    chk("ovf_busy1", {31'd0, exc_busy}, 32'd1);
    idle();
    chk("ovf_busy2", {31'd0, exc_busy}, 32'd1);
    chk("ovf_epc", epc, 32'h20);
    chk("ovf_cause", {30'd0, cause}, 32'd2);
    idle();
    chk("ovf_vec", pc, 32'h84);
    chk("ovf_busy_end", {31'd0, exc_busy}, 32'd0);

    // Opcode beats overflow
    load(32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    idle();
    chk("opc_cause", {30'd0, cause}, 32'd1);
    chk("opc_epc", epc, 32'h4);
    chk("opc_vec", pc, 32'h80);

    // Misaligned target, with loads attempted during SAVE and VECTOR
    load(32'h30);
    load(32'h42);
    chk("mis_hold_pc", pc, 32'h30);
    step(1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mis_epc", epc, 32'h30);
    chk("mis_cause", {30'd0, cause}, 32'd3);
    chk("mis_vec", pc, 32'h88);
    idle();
    chk("mis_no_queue", {31'd0, exc_busy}, 32'd0);

    // Return from handler via normal load of epc
    load(epc);
    chk("ret_pc", pc, 32'h30);

    // Reset during SAVE aborts entry
    load(32'h50);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_pc", pc, RESET_PC);
    chk("abort_epc", epc, 32'h0);
    chk("abort_cause", {30'd0, cause}, 32'd0);
    chk("abort_busy", {31'd0, exc_busy}, 32'd0);

    // EPC wrap at pc=0
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    idle();
    chk("wrap_vec", pc, 32'h84);

    // Randomised traffic checked against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      step(($urandom_range(0, 59) == 0), a,
           ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 14) == 0), ($urandom_range(0, 14) == 0));
    end

    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
